// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, ALU/condition codes, FSM states and control word for the multi-cycle controller
package multicycle_ctrl_pkg;
  localparam int OPW = 6;
  localparam int ALUOPW = 4;
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;
  localparam logic [OPW-1:0] OP_ALU  = 6'd0;
  localparam logic [OPW-1:0] OP_ALUI = 6'd1;
  localparam logic [OPW-1:0] OP_LD   = 6'd2;
  localparam logic [OPW-1:0] OP_ST   = 6'd3;
  localparam logic [OPW-1:0] OP_BR   = 6'd4;
  localparam logic [OPW-1:0] OP_HALT = 6'd63;
  localparam logic [ALUOPW-1:0] ALU_ADD = 4'd0;
  localparam logic [1:0] COND_ALWAYS  = 2'd0;
  localparam logic [1:0] COND_LESS    = 2'd1;
  localparam logic [1:0] COND_GREATER = 2'd2;
  localparam logic [1:0] COND_EQUAL   = 2'd3;
  typedef struct packed {
    logic              mem_req;
    logic              mem_we;
    logic              iord_sel;
    logic              ir_write;
    logic              pc_write;
    logic              pc_src_sel;
    logic              alu_src_sel;
    logic [ALUOPW-1:0] alu_op;
    logic [1:0]        cond_sel;
    logic              reg_we;
    logic              wb_sel;
    logic              instr_done;
    logic              halted;
  } ctrl_t;
  function automatic logic op_known(input logic [OPW-1:0] op);
    return op inside {OP_ALU, OP_ALUI, OP_LD, OP_ST, OP_BR, OP_HALT};
  endfunction
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: IR fields, condition result, memory handshake and datapath controls; RETIRE_CNT_EN adds retire_cnt
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;
  logic [OPW-1:0]    opcode;
  logic [ALUOPW-1:0] funct;
  logic [1:0]        br_cond;
  logic              cond_met;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_we;
  logic              iord_sel;
  logic              ir_write;
  logic              pc_write;
  logic              pc_src_sel;
  logic              alu_src_sel;
  logic [ALUOPW-1:0] alu_op;
  logic [1:0]        cond_sel;
  logic              reg_we;
  logic              wb_sel;
  logic              instr_done;
  logic              illegal_op;
  logic              halted;
`ifdef RETIRE_CNT_EN
  logic [31:0]       retire_cnt;
`endif
  modport master (
    input  opcode, funct, br_cond, cond_met, mem_ready,
    output mem_req, mem_we, iord_sel, ir_write, pc_write, pc_src_sel, alu_src_sel,
           alu_op, cond_sel, reg_we, wb_sel, instr_done, illegal_op, halted
`ifdef RETIRE_CNT_EN
    , output retire_cnt
`endif
  );
  modport slave (
    output opcode, funct, br_cond, cond_met, mem_ready,
    input  mem_req, mem_we, iord_sel, ir_write, pc_write, pc_src_sel, alu_src_sel,
           alu_op, cond_sel, reg_we, wb_sel, instr_done, illegal_op, halted
`ifdef RETIRE_CNT_EN
    , input retire_cnt
`endif
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// multicycle_ctrl_decode: combinational state+opcode to control word
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  state_e            state_i,
  input  logic [OPW-1:0]    opcode_i,
  input  logic [ALUOPW-1:0] funct_i,
  input  logic [1:0]        br_cond_i,
  input  logic              cond_met_i,
  input  logic              mem_ready_i,
  output ctrl_t             ctrl_o
);
  always_comb begin
    ctrl_o = '0;
    ctrl_o.alu_op = ALU_ADD;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.ir_write = mem_ready_i;
        ctrl_o.pc_write = mem_ready_i;
      end
      S_DECODE: ctrl_o.instr_done = !op_known(opcode_i);
      S_EXEC: begin
        ctrl_o.alu_src_sel = opcode_i inside {OP_ALUI, OP_LD, OP_ST};
        ctrl_o.alu_op = (opcode_i inside {OP_ALU, OP_ALUI}) ? funct_i : ALU_ADD;
        ctrl_o.cond_sel = (opcode_i == OP_BR) ? br_cond_i : 2'd0;
        ctrl_o.pc_src_sel = opcode_i == OP_BR;
        ctrl_o.pc_write = (opcode_i == OP_BR) && cond_met_i;
        ctrl_o.instr_done = opcode_i == OP_BR;
      end
      S_MEM: begin
        ctrl_o.mem_req = 1'b1;
        ctrl_o.iord_sel = 1'b1;
        ctrl_o.mem_we = opcode_i == OP_ST;
        ctrl_o.instr_done = (opcode_i == OP_ST) && mem_ready_i;
      end
      S_WB: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.wb_sel = opcode_i == OP_LD;
        ctrl_o.instr_done = 1'b1;
      end
      S_HALT: ctrl_o.halted = 1'b1;
      default: ctrl_o = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb sequencer; define RETIRE_CNT_EN for the retire_cnt counter
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input logic clk,
  input logic rst,
  multicycle_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic illegal_q, illegal_d;
  ctrl_t ctrl, ctrl_g;
  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .br_cond_i   (bus.br_cond),
    .cond_met_i  (bus.cond_met),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: state_d = (bus.opcode == OP_HALT) ? S_HALT : op_known(bus.opcode) ? S_EXEC : S_FETCH;
      S_EXEC:   state_d = (bus.opcode inside {OP_ALU, OP_ALUI}) ? S_WB :
                          (bus.opcode inside {OP_LD, OP_ST}) ? S_MEM : S_FETCH;
      S_MEM:    state_d = !bus.mem_ready ? S_MEM : (bus.opcode == OP_LD) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    illegal_d = illegal_q | ((state_q == S_DECODE) && !op_known(bus.opcode));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      illegal_q <= illegal_d;
    end
  end
  // reset masks every output combinationally so a mid-access reset drops mem_req at once
  assign ctrl_g = rst ? '0 : ctrl;
  assign bus.mem_req = ctrl_g.mem_req;
  assign bus.mem_we = ctrl_g.mem_we;
  assign bus.iord_sel = ctrl_g.iord_sel;
  assign bus.ir_write = ctrl_g.ir_write;
  assign bus.pc_write = ctrl_g.pc_write;
  assign bus.pc_src_sel = ctrl_g.pc_src_sel;
  assign bus.alu_src_sel = ctrl_g.alu_src_sel;
  assign bus.alu_op = ctrl_g.alu_op;
  assign bus.cond_sel = ctrl_g.cond_sel;
  assign bus.reg_we = ctrl_g.reg_we;
  assign bus.wb_sel = ctrl_g.wb_sel;
  assign bus.instr_done = ctrl_g.instr_done;
  assign bus.halted = ctrl_g.halted;
  assign bus.illegal_op = illegal_q & ~rst;
`ifdef RETIRE_CNT_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_q + {31'd0, ctrl.instr_done};
  end
  assign bus.retire_cnt = rst ? '0 : cnt_q;
`endif
endmodule
